dadda_mac_pipe: RTL and testbench
=================================

DADDA_MAC_PIPE -- requirements
Module: dadda_mac_pipe

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits, legal range 4..32.
REQ-002 Parameter ACC_WIDTH, default 2*WIDTH+8: result and accumulator width in bits, SHALL be >= 2*WIDTH.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  the operand beat on A, B and acc_en is valid.
REQ-006 in_ready  output  1  the block accepts a beat this cycle.
REQ-007 A  input  WIDTH  multiplicand.
REQ-008 B  input  WIDTH  multiplier.
REQ-009 acc_en  input  1  add the product to the accumulator (1) or load the product alone (0).
REQ-010 out_valid  output  1  P holds a valid result.
REQ-011 out_ready  input  1  the downstream consumer takes P this cycle.
REQ-012 P  output  ACC_WIDTH  result.

Function
REQ-013 Three pipeline stages. S1: register A, B and acc_en. S2: generate partial products, reduce them with a Dadda tree of full/half-adder cells to two rows, and register the sum and carry rows. S3: carry-propagate add of the two rows plus the optional accumulator, registered into P.
REQ-014 Latency from an accepted beat to out_valid SHALL be exactly 3 cycles when there is no stall.
REQ-015 A beat is accepted when in_valid && in_ready; a result is consumed when out_valid && out_ready.
REQ-016 Global stall: advance = !out_valid || out_ready; in_ready SHALL equal advance; while advance is low, every stage register, valid bit and the accumulator SHALL hold.
REQ-017 Each stage SHALL carry its own valid bit; bubbles SHALL propagate as invalid stages and never update the accumulator.
REQ-018 When a valid beat leaves S3 with acc_en=1: P = ACC + A*B modulo 2^ACC_WIDTH, and ACC <= that value.
REQ-019 When a valid beat leaves S3 with acc_en=0: P = A*B (zero- or sign-extended per REQ-025), and ACC <= P.
REQ-020 Accumulator overflow SHALL wrap modulo 2^ACC_WIDTH with no flag.
REQ-021 Back-to-back beats with acc_en=1 SHALL accumulate every product exactly once, including across stalls.
REQ-022 P and out_valid SHALL hold stable while out_valid && !out_ready.

Reset
REQ-023 rst=1 at a clock edge SHALL clear all stage valid bits, out_valid, P and ACC to 0, discarding in-flight beats; in_ready SHALL read 1 in the cycle after reset.
REQ-024 A beat presented in the same cycle as rst SHALL NOT be accepted.

Configuration
REQ-025 Macro DADDA_SIGNED_EN. When defined, A and B are two's-complement and partial products use Baugh-Wooley sign correction, with P sign-extended to ACC_WIDTH. When undefined, operands are unsigned and P is zero-extended to ACC_WIDTH.

Verification
REQ-026 Unsigned, WIDTH=8: A=0xFF, B=0xFF, acc_en=0 -> after 3 cycles P=0x0000FE01 (ACC_WIDTH=24: 0x00FE01), out_valid=1.
REQ-027 Accumulate: beats (3,4,acc_en=0), (5,6,1) and (7,8,1) on consecutive cycles with out_ready=1 -> P sequence 12, 42, 98 on consecutive cycles.
REQ-028 Stall: hold out_ready=0 for 4 cycles with 3 beats in flight -> in_ready=0 and P held; release -> 3 results in order, none lost or duplicated.
REQ-029 DADDA_SIGNED_EN defined: A=0x80, B=0x80 -> P=0x004000; A=0xFF, B=0x01 -> P=0xFFFFFF.
REQ-030 Wrap: ACC=0xFFFFFF, then a beat 1*1 with acc_en=1 -> P=0x000000.
REQ-031 Reset mid-operation: assert rst with 2 beats in flight -> out_valid, P and ACC all 0 next cycle, and no stale result ever appears.

Source files
------------

// File: rtl/dadda_mac_pipe.sv
// dadda_mac_pipe: 3-stage Dadda-tree multiply-accumulate with global stall; define DADDA_SIGNED_EN for two's-complement operands
module dadda_mac_pipe #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 2*WIDTH+8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 acc_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] P
);
  localparam int C = 2*WIDTH;
  localparam int H = WIDTH;
  function automatic int stage_d(input int j);
    int d;
    d = 2;
    for (int k = 0; k < j; k++) d = d*3/2;
    return d;
  endfunction
  function automatic int num_stages(input int h);
    int n;
    n = 0;
    while (stage_d(n) < h) n++;
    return n;
  endfunction
  localparam int NS = num_stages(H);
  logic                 advance, v1, e1, v2, e2;
  logic [WIDTH-1:0]     a1, b1;
  logic [C-1:0]         s_row, c_row, s2, c2, prod;
  logic [ACC_WIDTH-1:0] ext, p_next;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  // Partial products reduced column by column to two rows, one Dadda height target per stage
  always_comb begin : tree
    logic [H-1:0] col [C];
    logic [H-1:0] nxt [C];
    int cnt [C];
    int nc [C];
    int k, h, d;
    logic sum, cry;
    k = 0;
    h = 0;
    d = 0;
    sum = 1'b0;
    cry = 1'b0;
    for (int i = 0; i < C; i++) begin
      col[i] = '0;
      nxt[i] = '0;
      cnt[i] = 0;
      nc[i] = 0;
    end
    for (int i = 0; i < WIDTH; i++)
      for (int j = 0; j < WIDTH; j++) begin
`ifdef DADDA_SIGNED_EN
        col[i+j][cnt[i+j]] = ((i == WIDTH-1) != (j == WIDTH-1)) ? ~(a1[i] & b1[j]) : (a1[i] & b1[j]);
`else
        col[i+j][cnt[i+j]] = a1[i] & b1[j];
`endif
        cnt[i+j] += 1;
      end
`ifdef DADDA_SIGNED_EN
    col[WIDTH][cnt[WIDTH]] = 1'b1;
    cnt[WIDTH] += 1;
    col[C-1][cnt[C-1]] = 1'b1;
    cnt[C-1] += 1;
`endif
    for (int s = NS-1; s >= 0; s--) begin
      d = stage_d(s);
      for (int i = 0; i < C; i++) begin
        nxt[i] = '0;
        nc[i] = 0;
      end
      for (int i = 0; i < C; i++) begin
        k = 0;
        h = cnt[i] + nc[i];
        for (int r = 0; r < H; r++)
          if (h > d && k+2 <= cnt[i]) begin
            if (h > d+1 && k+3 <= cnt[i]) begin
              sum = col[i][k] ^ col[i][k+1] ^ col[i][k+2];
              cry = (col[i][k] & col[i][k+1]) | (col[i][k+2] & (col[i][k] ^ col[i][k+1]));
              k += 3;
              h -= 2;
            end else begin
              sum = col[i][k] ^ col[i][k+1];
              cry = col[i][k] & col[i][k+1];
              k += 2;
              h -= 1;
            end
            nxt[i][nc[i]] = sum;
            nc[i] += 1;
            if (i+1 < C) begin
              nxt[(i+1)%C][nc[(i+1)%C]] = cry;
              nc[(i+1)%C] += 1;
            end
          end
        for (int r = 0; r < H; r++)
          if (r >= k && r < cnt[i]) begin
            nxt[i][nc[i]] = col[i][r];
            nc[i] += 1;
          end
      end
      col = nxt;
      cnt = nc;
    end
    for (int i = 0; i < C; i++) begin
      s_row[i] = col[i][0];
      c_row[i] = col[i][1];
    end
  end
  assign prod = s2 + c2;
`ifdef DADDA_SIGNED_EN
  assign ext = ACC_WIDTH'($signed(prod));
`else
  assign ext = ACC_WIDTH'(prod);
`endif
  assign p_next = e2 ? P + ext : ext;
  // Pipeline advances in lockstep; P doubles as the accumulator
  always_ff @(posedge clk)
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      out_valid <= 1'b0;
      P <= '0;
    end else if (advance) begin
      v1 <= in_valid;
      a1 <= A;
      b1 <= B;
      e1 <= acc_en;
      v2 <= v1;
      s2 <= s_row;
      c2 <= c_row;
      e2 <= e1;
      out_valid <= v2;
      if (v2) P <= p_next;
    end
endmodule

// File: tb/tb_dadda_mac_pipe.sv
// tb_dadda_mac_pipe: randomized and directed checks of dadda_mac_pipe against an arithmetic model
module tb_dadda_mac_pipe;
  localparam int W = 8;
  localparam int AW = 24;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, acc_en = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid;
  logic [W-1:0] A = '0, B = '0;
  logic [AW-1:0] P;
  int passed = 0, total = 0;
  logic [AW-1:0] exp_q [$];
  logic [AW-1:0] got_q [$];
  logic [AW-1:0] macc = '0;

  always #5 clk = ~clk;

  dadda_mac_pipe #(.WIDTH(W), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .acc_en(acc_en), .out_valid(out_valid), .out_ready(out_ready), .P(P)
  );

  function automatic logic [AW-1:0] mul(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef DADDA_SIGNED_EN
    logic signed [AW-1:0] x, y;
`else
    logic [AW-1:0] x, y;
`endif
    x = a;
`ifdef DADDA_SIGNED_EN
    x = $signed(a);
    y = $signed(b);
`else
    y = b;
`endif
    return x * y;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      got_q.delete();
      macc = '0;
    end else begin
      if (in_valid && in_ready) begin
        macc = acc_en ? macc + mul(A, B) : mul(A, B);
        exp_q.push_back(macc);
      end
      if (out_valid && out_ready) got_q.push_back(P);
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic e);
    int n;
    A = a; B = b; acc_en = e; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++;
      $display("FAIL send: in_ready stuck at %b, required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      if (got_q.size() == exp_q.size()) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; A = 8'd5; B = 8'd7;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid === 1'b0) passed++; else $display("FAIL reset out_valid: got %b, required 0", out_valid);
    total++; if (P === '0) passed++; else $display("FAIL reset P: got %h, required 000000", P);
    total++; if (in_ready === 1'b1) passed++; else $display("FAIL reset in_ready: got %b, required 1", in_ready);
    repeat (5) @(negedge clk);
    total++; if (got_q.size() == 0) passed++; else $display("FAIL reset beat accepted: got %0d results, required 0", got_q.size());
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    logic [AW-1:0] want;
`ifdef DADDA_SIGNED_EN
    want = 24'h000001;
`else
    want = 24'h00FE01;
`endif
    out_ready = 1'b1; A = 8'hFF; B = 8'hFF; acc_en = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid === 1'b0) passed++; else $display("FAIL latency cycle1 out_valid: got %b, required 0", out_valid);
    @(negedge clk);
    total++; if (out_valid === 1'b0) passed++; else $display("FAIL latency cycle2 out_valid: got %b, required 0", out_valid);
    @(negedge clk);
    total++; if ({out_valid, P} === {1'b1, want}) passed++; else $display("FAIL latency cycle3: got valid=%b P=%h, required valid=1 P=%h", out_valid, P, want);
    @(posedge clk); #1;
  endtask

  task automatic test_accumulate();
    logic [W-1:0] av [3] = '{8'd3, 8'd5, 8'd7};
    logic [W-1:0] bv [3] = '{8'd4, 8'd6, 8'd8};
    logic [AW-1:0] want [3] = '{24'd12, 24'd42, 24'd98};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      A = av[i]; B = bv[i]; acc_en = (i != 0); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if ({out_valid, P} === {1'b1, want[i]}) passed++; else $display("FAIL accumulate %0d: got valid=%b P=%0d, required valid=1 P=%0d", i, out_valid, P, want[i]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    bit ok;
    exp_q.delete(); got_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      A = 8'(2*i+2); B = 8'(2*i+3); acc_en = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      total++; if (in_ready === 1'b0) passed++; else $display("FAIL stall in_ready: got %b, required 0", in_ready);
      total++; if ({out_valid, P} === {1'b1, exp_q[0]}) passed++; else $display("FAIL stall hold: got valid=%b P=%h, required valid=1 P=%h", out_valid, P, exp_q[0]);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_drain(ok);
    total++; if (ok && got_q.size() == 3 && exp_q.size() == 3) passed++; else $display("FAIL stall count: got %0d results, required 3", got_q.size());
    foreach (exp_q[i]) begin
      total++; if (i < got_q.size() && got_q[i] === exp_q[i]) passed++; else $display("FAIL stall result %0d: got %h, required %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
    end
  endtask

`ifdef DADDA_SIGNED_EN
  task automatic test_signed();
    bit ok;
    exp_q.delete(); got_q.delete();
    out_ready = 1'b1;
    send(8'h80, 8'h80, 1'b0);
    send(8'hFF, 8'h01, 1'b0);
    wait_drain(ok);
    total++; if (ok && got_q.size() == 2 && got_q[0] === 24'h004000) passed++; else $display("FAIL signed 0x80*0x80: got %h, required 004000", (got_q.size() > 0) ? got_q[0] : 'x);
    total++; if (got_q.size() == 2 && got_q[1] === 24'hFFFFFF) passed++; else $display("FAIL signed 0xFF*0x01: got %h, required FFFFFF", (got_q.size() > 1) ? got_q[1] : 'x);
  endtask
`else
  task automatic test_wrap();
    bit ok;
    exp_q.delete(); got_q.delete();
    out_ready = 1'b1;
    send(8'hFF, 8'hFF, 1'b0);
    repeat (257) send(8'hFF, 8'hFF, 1'b1);
    send(8'hFF, 8'h03, 1'b1);
    send(8'h01, 8'h01, 1'b1);
    wait_drain(ok);
    total++; if (ok && got_q.size() == 260) passed++; else $display("FAIL wrap count: got %0d results, required 260", got_q.size());
    total++; if (got_q.size() == 260 && got_q[258] === 24'hFFFFFF) passed++; else $display("FAIL wrap full: got %h, required FFFFFF", (got_q.size() > 258) ? got_q[258] : 'x);
    total++; if (got_q.size() == 260 && got_q[259] === 24'h000000) passed++; else $display("FAIL wrap zero: got %h, required 000000", (got_q.size() > 259) ? got_q[259] : 'x);
  endtask
`endif

  task automatic test_random(input int n);
    bit ok;
    int cyc;
    exp_q.delete(); got_q.delete();
    cyc = 0;
    while (exp_q.size() < n && cyc < 40*n) begin
      in_valid = ($urandom_range(3) != 0);
      A = ($urandom_range(7) == 0) ? 8'hFF : 8'($urandom);
      B = ($urandom_range(7) == 0) ? 8'h80 : 8'($urandom);
      acc_en = 1'($urandom_range(1));
      out_ready = ($urandom_range(3) != 0);
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    wait_drain(ok);
    total++; if (ok && got_q.size() == n && exp_q.size() == n) passed++; else $display("FAIL random count: got %0d results, required %0d", got_q.size(), n);
    foreach (exp_q[i]) begin
      total++; if (i < got_q.size() && got_q[i] === exp_q[i]) passed++; else $display("FAIL random result %0d: got %h, required %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    exp_q.delete(); got_q.delete();
    out_ready = 1'b1;
    A = 8'd9; B = 8'd9; acc_en = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    A = 8'd2; B = 8'd2; acc_en = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    total++; if (out_valid === 1'b0) passed++; else $display("FAIL reset_mid out_valid: got %b, required 0", out_valid);
    total++; if (P === '0) passed++; else $display("FAIL reset_mid P: got %h, required 000000", P);
    repeat (5) @(negedge clk);
    total++; if (got_q.size() == 0) passed++; else $display("FAIL reset_mid stale: got %0d results, required 0", got_q.size());
    @(posedge clk); #1;
    send(8'd3, 8'd4, 1'b1);
    wait_drain(ok);
    total++; if (ok && got_q.size() == 1 && got_q[0] === 24'd12) passed++; else $display("FAIL reset_mid acc: got %h, required 00000c", (got_q.size() > 0) ? got_q[0] : 'x);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_accumulate();
    test_stall();
`ifdef DADDA_SIGNED_EN
    test_signed();
`else
    test_wrap();
`endif
    test_random(300);
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
